change_payout_sequencer: RTL

//  Sequences coin-hopper actuators (C10, C5, C1) to pay out a requested change amount.

---
 rtl/change_payout_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/change_payout_sequencer.sv
// change_payout_sequencer: greedy 10/5/1 coin-hopper pulse sequencer with per-denomination inventory
module change_payout_sequencer #(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 4,
    parameter int CNT_W     = 8
) (
    input  logic             MAX10_CLK1_50,
    input  logic             nRESET,
    input  logic             req_valid,
    input  logic [7:0]       req_amount,
    output logic             req_ready,
    input  logic             inv_load,
    input  logic [1:0]       inv_sel,
    input  logic [CNT_W-1:0] inv_value,
    output logic             C1,
    output logic             C5,
    output logic             C10,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [7:0]       remaining,
    output logic [CNT_W-1:0] inv1,
    output logic [CNT_W-1:0] inv5,
    output logic [CNT_W-1:0] inv10
);
    typedef enum logic [2:0] {IDLE, SELECT, FIRE, GAP, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] tmr_q, tmr_d, rem_q, rem_d;
    logic [1:0] coin_q, coin_d, pick;
    logic [CNT_W-1:0] inv1_q, inv1_d, inv5_q, inv5_d, inv10_q, inv10_d;
    logic c1_q, c1_d, c5_q, c5_d, c10_q, c10_d;
    logic busy_q, busy_d, done_q, done_d, short_q, short_d;
    assign pick = (rem_q >= 8'd10 && inv10_q != '0) ? 2'd3 :
                  (rem_q >= 8'd5  && inv5_q  != '0) ? 2'd2 :
                  (rem_q != 8'd0  && inv1_q  != '0) ? 2'd1 : 2'd0;
    // next-state: coin choice in SELECT, inventory/balance debit on the first FIRE cycle
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rem_d   = rem_q;
        coin_d  = coin_q;
        inv1_d  = inv1_q;
        inv5_d  = inv5_q;
        inv10_d = inv10_q;
        short_d = short_q;
        case (state_q)
            IDLE: begin
                if (inv_load) begin
                    inv1_d  = (inv_sel == 2'd0) ? inv_value : inv1_q;
                    inv5_d  = (inv_sel == 2'd1) ? inv_value : inv5_q;
                    inv10_d = (inv_sel == 2'd2) ? inv_value : inv10_q;
                end
                if (req_valid) begin
                    rem_d   = req_amount;
                    short_d = 1'b0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (pick != 2'd0) begin
                    coin_d  = pick;
                    tmr_d   = '0;
                    state_d = FIRE;
                end else begin
                    short_d = rem_q != 8'd0;
                    state_d = DONE;
                end
            end
            FIRE: begin
                tmr_d = tmr_q + 8'd1;
                if (tmr_q == '0) begin
                    inv10_d = (coin_q == 2'd3 && inv10_q != '0) ? inv10_q - CNT_W'(1) : inv10_q;
                    inv5_d  = (coin_q == 2'd2 && inv5_q  != '0) ? inv5_q  - CNT_W'(1) : inv5_q;
                    inv1_d  = (coin_q == 2'd1 && inv1_q  != '0) ? inv1_q  - CNT_W'(1) : inv1_q;
                    rem_d   = rem_q - ((coin_q == 2'd3) ? 8'd10 : (coin_q == 2'd2) ? 8'd5 : 8'd1);
                end
                if (tmr_q == 8'(PULSE_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                tmr_d = tmr_q + 8'd1;
                if (tmr_q == 8'(GAP_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = SELECT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // registered outputs: actuators follow the FIRE state, done follows DONE
    always_comb begin
        c1_d   = state_q == FIRE && coin_q == 2'd1;
        c5_d   = state_q == FIRE && coin_q == 2'd2;
        c10_d  = state_q == FIRE && coin_q == 2'd3;
        done_d = state_q == DONE;
        busy_d = state_d != IDLE;
    end
    // state and output registers with synchronous active-low reset
    always_ff @(posedge MAX10_CLK1_50) begin
        if (!nRESET) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            rem_q   <= '0;
            coin_q  <= '0;
            inv1_q  <= '0;
            inv5_q  <= '0;
            inv10_q <= '0;
            c1_q    <= 1'b0;
            c5_q    <= 1'b0;
            c10_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            coin_q  <= coin_d;
            inv1_q  <= inv1_d;
            inv5_q  <= inv5_d;
            inv10_q <= inv10_d;
            c1_q    <= c1_d;
            c5_q    <= c5_d;
            c10_q   <= c10_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            short_q <= short_d;
        end
    end
    assign req_ready = ~busy_q;
    assign C1        = c1_q;
    assign C5        = c5_q;
    assign C10       = c10_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign short     = short_q;
    assign remaining = rem_q;
    assign inv1      = inv1_q;
    assign inv5      = inv5_q;
    assign inv10     = inv10_q;
endmodule
